// File: rtl/nandc_wb_arbiter_n.sv
// Wishbone N-master to single-slave arbiter: non-preemptive grant, fixed priority
// (highest index wins) or round-robin, with one idle cycle between consecutive grants.
module nandc_wb_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int RR_EN       = 0
) (
  input  logic                          wb_clk,
  input  logic                          wb_rst,
  input  logic [3*NUM_MASTERS-1:0]      m_cti_i,
  input  logic [2*NUM_MASTERS-1:0]      m_bte_i,
  input  logic [AW*NUM_MASTERS-1:0]     m_adr_i,
  input  logic [DW*NUM_MASTERS-1:0]     m_dat_i,
  input  logic [(DW/8)*NUM_MASTERS-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  output logic [DW*NUM_MASTERS-1:0]     m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [2:0]                    s_cti_o,
  output logic [1:0]                    s_bte_o,
  output logic [AW-1:0]                 s_adr_o,
  output logic [DW-1:0]                 s_dat_o,
  output logic [DW/8-1:0]               s_sel_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  input  logic [DW-1:0]                 s_dat_i,
  input  logic                          s_ack_i,
  output logic [NUM_MASTERS-1:0]        gnt_o
);

  localparam int SW = DW / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

  // Handshake: a master owns the slave from grant until it drops cyc. While it
  // owns the bus each beat is stb (valid) qualified by s_ack_i (ready) and
  // completes on the wb_clk edge where both are high; only the owner sees ack.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]           last_q, last_d;
  logic [IW-1:0]           gnt_idx;
  logic [IW-1:0]           win_fp;
  logic [IW-1:0]           win_rr;
  logic [IW-1:0]           win;
  logic                    rr_found;
  int                      rr_idx;

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (gnt_q[k]) gnt_idx = IW'(k);
    end
  end

  // Later matches overwrite earlier ones, so the highest requesting index wins.
  always_comb begin
    win_fp = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (m_cyc_i[k]) win_fp = IW'(k);
    end
  end

  always_comb begin
    win_rr   = last_q;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int s = 1; s <= NUM_MASTERS; s++) begin
      rr_idx = (int'(last_q) + s) % NUM_MASTERS;
      if (!rr_found && m_cyc_i[rr_idx]) begin
        win_rr   = IW'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  assign win = (RR_EN != 0) ? win_rr : win_fp;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d      = GRANT;
          gnt_d        = '0;
          gnt_d[win]   = 1'b1;
        end
      end
      GRANT: begin
        // Other requesters are ignored until the owner drops cyc.
        if (!m_cyc_i[gnt_idx]) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = gnt_idx;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    s_cti_o = '0;
    s_bte_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    if (state_q == GRANT) begin
      s_cti_o = m_cti_i[gnt_idx*3 +: 3];
      s_bte_o = m_bte_i[gnt_idx*2 +: 2];
      s_adr_o = m_adr_i[gnt_idx*AW +: AW];
      s_dat_o = m_dat_i[gnt_idx*DW +: DW];
      s_sel_o = m_sel_i[gnt_idx*SW +: SW];
      s_cyc_o = m_cyc_i[gnt_idx];
      s_stb_o = m_stb_i[gnt_idx];
      s_we_o  = m_we_i[gnt_idx];
    end
  end

  assign m_ack_o = gnt_q & {NUM_MASTERS{s_ack_i}};
  assign gnt_o   = gnt_q;

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_rdata
    assign m_dat_o[k*DW +: DW] = gnt_q[k] ? s_dat_i : '0;
  end

endmodule

// File: tb/tb_nandc_wb_arbiter_n.sv
// Bench for nandc_wb_arbiter_n: four configurations (N=4 fixed, N=4 round-robin,
// N=1, N=2 fixed) checked every cycle against an ownership-level reference model.
module tb_nandc_wb_arbiter_n;

  // ---------------- clock / reset ----------------
  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;
  always #5 wb_clk = ~wb_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus storage: [instance][master] ----------------
  // instance 0 = N4 fixed, 1 = N4 round-robin, 2 = N1, 3 = N2 fixed
  logic [2:0]  cti [4][4];
  logic [1:0]  bte [4][4];
  logic [31:0] adr [4][4];
  logic [31:0] dat [4][4];
  logic [3:0]  sel [4][4];
  logic        cyc [4][4];
  logic        stb [4][4];
  logic        we  [4][4];
  logic [31:0] sdat [4];
  logic        sack [4];

  logic [2:0]  o_scti [4];
  logic [1:0]  o_sbte [4];
  logic [31:0] o_sadr [4];
  logic [31:0] o_sdat [4];
  logic [3:0]  o_ssel [4];
  logic        o_scyc [4];
  logic        o_sstb [4];
  logic        o_swe  [4];

  logic [3:0]   a_gnt, a_mack, b_gnt, b_mack;
  logic [127:0] a_mdat, b_mdat;
  logic [0:0]   c_gnt, c_mack;
  logic [31:0]  c_mdat;
  logic [1:0]   d_gnt, d_mack;
  logic [63:0]  d_mdat;

  nandc_wb_arbiter_n #(.NUM_MASTERS(4), .DW(32), .AW(32), .RR_EN(0)) u_a (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m_cti_i({cti[0][3], cti[0][2], cti[0][1], cti[0][0]}),
    .m_bte_i({bte[0][3], bte[0][2], bte[0][1], bte[0][0]}),
    .m_adr_i({adr[0][3], adr[0][2], adr[0][1], adr[0][0]}),
    .m_dat_i({dat[0][3], dat[0][2], dat[0][1], dat[0][0]}),
    .m_sel_i({sel[0][3], sel[0][2], sel[0][1], sel[0][0]}),
    .m_cyc_i({cyc[0][3], cyc[0][2], cyc[0][1], cyc[0][0]}),
    .m_stb_i({stb[0][3], stb[0][2], stb[0][1], stb[0][0]}),
    .m_we_i ({we[0][3],  we[0][2],  we[0][1],  we[0][0]}),
    .m_dat_o(a_mdat), .m_ack_o(a_mack),
    .s_cti_o(o_scti[0]), .s_bte_o(o_sbte[0]), .s_adr_o(o_sadr[0]), .s_dat_o(o_sdat[0]),
    .s_sel_o(o_ssel[0]), .s_cyc_o(o_scyc[0]), .s_stb_o(o_sstb[0]), .s_we_o(o_swe[0]),
    .s_dat_i(sdat[0]), .s_ack_i(sack[0]), .gnt_o(a_gnt)
  );

  nandc_wb_arbiter_n #(.NUM_MASTERS(4), .DW(32), .AW(32), .RR_EN(1)) u_b (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m_cti_i({cti[1][3], cti[1][2], cti[1][1], cti[1][0]}),
    .m_bte_i({bte[1][3], bte[1][2], bte[1][1], bte[1][0]}),
    .m_adr_i({adr[1][3], adr[1][2], adr[1][1], adr[1][0]}),
    .m_dat_i({dat[1][3], dat[1][2], dat[1][1], dat[1][0]}),
    .m_sel_i({sel[1][3], sel[1][2], sel[1][1], sel[1][0]}),
    .m_cyc_i({cyc[1][3], cyc[1][2], cyc[1][1], cyc[1][0]}),
    .m_stb_i({stb[1][3], stb[1][2], stb[1][1], stb[1][0]}),
    .m_we_i ({we[1][3],  we[1][2],  we[1][1],  we[1][0]}),
    .m_dat_o(b_mdat), .m_ack_o(b_mack),
    .s_cti_o(o_scti[1]), .s_bte_o(o_sbte[1]), .s_adr_o(o_sadr[1]), .s_dat_o(o_sdat[1]),
    .s_sel_o(o_ssel[1]), .s_cyc_o(o_scyc[1]), .s_stb_o(o_sstb[1]), .s_we_o(o_swe[1]),
    .s_dat_i(sdat[1]), .s_ack_i(sack[1]), .gnt_o(b_gnt)
  );

  nandc_wb_arbiter_n #(.NUM_MASTERS(1), .DW(32), .AW(32), .RR_EN(0)) u_c (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m_cti_i(cti[2][0]), .m_bte_i(bte[2][0]), .m_adr_i(adr[2][0]), .m_dat_i(dat[2][0]),
    .m_sel_i(sel[2][0]), .m_cyc_i(cyc[2][0]), .m_stb_i(stb[2][0]), .m_we_i(we[2][0]),
    .m_dat_o(c_mdat), .m_ack_o(c_mack),
    .s_cti_o(o_scti[2]), .s_bte_o(o_sbte[2]), .s_adr_o(o_sadr[2]), .s_dat_o(o_sdat[2]),
    .s_sel_o(o_ssel[2]), .s_cyc_o(o_scyc[2]), .s_stb_o(o_sstb[2]), .s_we_o(o_swe[2]),
    .s_dat_i(sdat[2]), .s_ack_i(sack[2]), .gnt_o(c_gnt)
  );

  nandc_wb_arbiter_n #(.NUM_MASTERS(2), .DW(32), .AW(32), .RR_EN(0)) u_d (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m_cti_i({cti[3][1], cti[3][0]}), .m_bte_i({bte[3][1], bte[3][0]}),
    .m_adr_i({adr[3][1], adr[3][0]}), .m_dat_i({dat[3][1], dat[3][0]}),
    .m_sel_i({sel[3][1], sel[3][0]}), .m_cyc_i({cyc[3][1], cyc[3][0]}),
    .m_stb_i({stb[3][1], stb[3][0]}), .m_we_i({we[3][1], we[3][0]}),
    .m_dat_o(d_mdat), .m_ack_o(d_mack),
    .s_cti_o(o_scti[3]), .s_bte_o(o_sbte[3]), .s_adr_o(o_sadr[3]), .s_dat_o(o_sdat[3]),
    .s_sel_o(o_ssel[3]), .s_cyc_o(o_scyc[3]), .s_stb_o(o_sstb[3]), .s_we_o(o_swe[3]),
    .s_dat_i(sdat[3]), .s_ack_i(sack[3]), .gnt_o(d_gnt)
  );

  // ---------------- reference model: who owns the bus ----------------
  int nm   [4] = '{4, 4, 1, 2};
  int rrm  [4] = '{0, 1, 0, 0};
  int owner[4] = '{-1, -1, -1, -1};
  int last [4] = '{3, 3, 0, 1};

  function automatic int pick(input int i);
    int r;
    int k;
    r = -1;
    if (rrm[i] != 0) begin
      for (int s = 1; s <= nm[i]; s++) begin
        k = (last[i] + s) % nm[i];
        if (r < 0 && cyc[i][k]) r = k;
      end
    end else begin
      for (int j = nm[i] - 1; j >= 0; j--) begin
        if (r < 0 && cyc[i][j]) r = j;
      end
    end
    return r;
  endfunction

  always @(posedge wb_clk or posedge wb_rst) begin
    for (int i = 0; i < 4; i++) begin
      if (wb_rst) begin
        owner[i] = -1;
        last[i]  = nm[i] - 1;
      end else if (owner[i] < 0) begin
        owner[i] = pick(i);
      end else if (!cyc[i][owner[i]]) begin
        last[i]  = owner[i];
        owner[i] = -1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  task automatic ck(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input int i);
    logic [3:0]   og, om, eg, em;
    logic [127:0] od, ed;
    logic [2:0]   ecti;
    logic [1:0]   ebte;
    logic [31:0]  eadr, edat;
    logic [3:0]   esel;
    logic         ecyc, estb, ewe;
    int o;
    case (i)
      0: begin og = a_gnt; om = a_mack; od = a_mdat; end
      1: begin og = b_gnt; om = b_mack; od = b_mdat; end
      2: begin og = {3'b0, c_gnt}; om = {3'b0, c_mack}; od = {96'b0, c_mdat}; end
      default: begin og = {2'b0, d_gnt}; om = {2'b0, d_mack}; od = {64'b0, d_mdat}; end
    endcase
    o = owner[i];
    eg = '0; em = '0; ed = '0; ecti = '0; ebte = '0; eadr = '0; edat = '0; esel = '0;
    ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
    if (o >= 0) begin
      eg[o] = 1'b1;
      em[o] = sack[i];
      ed[o*32 +: 32] = sdat[i];
      ecti = cti[i][o]; ebte = bte[i][o]; eadr = adr[i][o]; edat = dat[i][o];
      esel = sel[i][o]; ecyc = cyc[i][o]; estb = stb[i][o]; ewe = we[i][o];
    end
    ck($sformatf("gnt_o[%0d]", i), og, eg);
    ck($sformatf("m_ack_o[%0d]", i), om, em);
    ck($sformatf("m_dat_o[%0d]", i), od, ed);
    ck($sformatf("s_cti_o[%0d]", i), o_scti[i], ecti);
    ck($sformatf("s_bte_o[%0d]", i), o_sbte[i], ebte);
    ck($sformatf("s_adr_o[%0d]", i), o_sadr[i], eadr);
    ck($sformatf("s_dat_o[%0d]", i), o_sdat[i], edat);
    ck($sformatf("s_sel_o[%0d]", i), o_ssel[i], esel);
    ck($sformatf("s_cyc_o[%0d]", i), o_scyc[i], ecyc);
    ck($sformatf("s_stb_o[%0d]", i), o_sstb[i], estb);
    ck($sformatf("s_we_o[%0d]", i), o_swe[i], ewe);
  endtask

  task automatic chk_all();
    for (int i = 0; i < 4; i++) chk(i);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge wb_clk);
    @(negedge wb_clk);
    chk_all();
  endtask

  task automatic set_master(input int i, input int k, input logic c, input logic [31:0] a);
    cyc[i][k] = c;
    stb[i][k] = c;
    adr[i][k] = a;
  endtask

  // ---------------- directed + random sequence ----------------
  int beats[4];
  int grants, idle_run, po;
  logic wa;
  logic [3:0] prev_g;

  initial begin
    for (int i = 0; i < 4; i++) begin
      sdat[i] = '0;
      sack[i] = 1'b0;
      beats[i] = 0;
      for (int k = 0; k < 4; k++) begin
        cti[i][k] = '0; bte[i][k] = '0; adr[i][k] = '0; dat[i][k] = '0;
        sel[i][k] = '0; cyc[i][k] = 1'b0; stb[i][k] = 1'b0; we[i][k] = 1'b0;
      end
    end

    // reset: everything zero while held
    repeat (2) @(negedge wb_clk);
    chk_all();
    wb_rst = 1'b0;
    cycle();

    // fixed priority, N=2: both request, master 1 wins and holds master 0 off
    set_master(3, 0, 1'b1, 32'h0000_0200);
    set_master(3, 1, 1'b1, 32'h0000_0300);
    #1 ck("d_idle_before_edge", d_gnt, 2'b00);
    cycle();
    ck("d_fp_first", d_gnt, 2'b10);
    sack[3] = 1'b1;
    sdat[3] = 32'hA5A5_0001;
    repeat (3) begin
      #1 ck("d_m0_no_ack", d_mack[0], 1'b0);
      cycle();
    end
    set_master(3, 1, 1'b0, 32'h0);
    sack[3] = 1'b0;
    cycle();
    ck("d_gap_gnt", d_gnt, 2'b00);
    ck("d_gap_cyc", o_scyc[3], 1'b0);
    cycle();
    ck("d_fp_second", d_gnt, 2'b01);
    set_master(3, 0, 1'b0, 32'h0);
    cycle();
    cycle();

    // burst pass-through on master 2 (N=4 fixed)
    set_master(0, 2, 1'b1, 32'h0000_0100);
    cti[0][2] = 3'b010;
    sel[0][2] = 4'hF;
    cycle();
    ck("a_burst_gnt", a_gnt, 4'b0100);
    for (int b = 0; b < 4; b++) begin
      adr[0][2] = 32'h0000_0100 + 32'(4 * b);
      cti[0][2] = (b == 3) ? 3'b111 : 3'b010;
      sack[0]   = 1'b1;
      sdat[0]   = 32'hDEAD_BEEF;
      #1;
      ck("a_burst_adr", o_sadr[0], 32'h0000_0100 + 32'(4 * b));
      ck("a_burst_cti", o_scti[0], (b == 3) ? 3'b111 : 3'b010);
      ck("a_burst_ack", a_mack, 4'b0100);
      ck("a_burst_rdata", a_mdat, {32'h0, 32'hDEAD_BEEF, 64'h0});
      cycle();
    end
    set_master(0, 2, 1'b0, 32'h0);
    sack[0] = 1'b0;
    cycle();
    cycle();

    // non-preemption: master 1 owns the bus while master 3 requests
    set_master(0, 1, 1'b1, 32'h0000_0400);
    cycle();
    ck("a_np_gnt", a_gnt, 4'b0010);
    set_master(0, 3, 1'b1, 32'h0000_0800);
    sack[0] = 1'b1;
    repeat (3) begin
      #1;
      ck("a_np_hold", a_gnt, 4'b0010);
      ck("a_np_m3_ack", a_mack[3], 1'b0);
      cycle();
    end
    set_master(0, 1, 1'b0, 32'h0);
    sack[0] = 1'b0;
    cycle();
    ck("a_np_gap", a_gnt, 4'b0000);
    cycle();
    ck("a_np_next", a_gnt, 4'b1000);
    set_master(0, 3, 1'b0, 32'h0);
    cycle();
    cycle();

    // N=1 pass-through write
    set_master(2, 0, 1'b1, 32'h0000_0040);
    we[2][0]  = 1'b1;
    dat[2][0] = 32'h1234_5678;
    sel[2][0] = 4'hF;
    #1 ck("c_not_yet", o_scyc[2], 1'b0);
    cycle();
    ck("c_cyc", o_scyc[2], 1'b1);
    ck("c_adr", o_sadr[2], 32'h0000_0040);
    ck("c_dat", o_sdat[2], 32'h1234_5678);
    ck("c_sel", o_ssel[2], 4'hF);
    ck("c_we", o_swe[2], 1'b1);
    sack[2] = 1'b1;
    #1 ck("c_ack_hi", c_mack, 1'b1);
    cycle();
    set_master(2, 0, 1'b0, 32'h0);
    we[2][0] = 1'b0;
    sack[2]  = 1'b0;
    cycle();
    ck("c_after_idle", o_scyc[2], 1'b0);
    cycle();

    // round-robin, N=4: everyone requests, each ends after 3 acks
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int k = 0; k < 4; k++) set_master(1, k, 1'b1, 32'h0000_1000 * (k + 1));
    grants = 0;
    idle_run = 0;
    prev_g = 4'b0000;
    for (int t = 0; t < 300 && grants < 5; t++) begin
      sack[1] = 1'($urandom_range(0, 1));
      sdat[1] = $urandom;
      po = owner[1];
      wa = (po >= 0) && sack[1] && stb[1][po];
      cycle();
      if (wa) begin
        beats[po]++;
        if (beats[po] == 3) begin
          set_master(1, po, 1'b0, adr[1][po]);
          beats[po] = 0;
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (!cyc[1][k] && owner[1] != k) set_master(1, k, 1'b1, adr[1][k]);
      end
      if (b_gnt != 4'b0000 && prev_g == 4'b0000) begin
        if (exp_q.size() > 0) ck("rr_order", b_gnt, exp_q.pop_front());
        if (grants > 0) ck("rr_idle_gap", idle_run, 1);
        grants++;
        idle_run = 0;
      end
      if (!o_scyc[1]) idle_run++;
      prev_g = b_gnt;
    end
    ck("rr_grant_count", grants, 5);
    ck("rr_queue_drained", exp_q.size(), 0);

    // asynchronous reset in the middle of a grant
    for (int k = 1; k < 4; k++) set_master(1, k, 1'b0, 32'h0);
    sack[1] = 1'b0;
    cycle();
    @(posedge wb_clk);
    #2 wb_rst = 1'b1;
    #1;
    ck("rst_scyc_async", o_scyc[1], 1'b0);
    ck("rst_gnt_async", b_gnt, 4'b0000);
    chk_all();
    #1 wb_rst = 1'b0;
    @(negedge wb_clk);
    chk_all();
    cycle();
    ck("rst_restart_m0", b_gnt, 4'b0001);
    set_master(1, 0, 1'b0, 32'h0);
    cycle();
    cycle();

    // randomized traffic on all four configurations
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < nm[i]; k++) begin
          if (owner[i] == k) cyc[i][k] = cyc[i][k] && ($urandom_range(0, 5) != 0);
          else               cyc[i][k] = ($urandom_range(0, 2) == 0);
          stb[i][k] = 1'($urandom_range(0, 1));
          we[i][k]  = 1'($urandom_range(0, 1));
          cti[i][k] = 3'($urandom_range(0, 7));
          bte[i][k] = 2'($urandom_range(0, 3));
          sel[i][k] = 4'($urandom_range(0, 15));
          adr[i][k] = $urandom;
          dat[i][k] = $urandom;
        end
        sack[i] = 1'($urandom_range(0, 1));
        sdat[i] = $urandom;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nandc_wb_arbiter_n.md
NANDC_WB_ARBITER_N -- requirements
Module: nandc_wb_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Wishbone master ports (legal 1..8).
REQ-002 SHALL have parameter DW, default 32, data width in bits (multiple of 8).
REQ-003 SHALL have parameter AW, default 32, address width in bits.
REQ-004 SHALL have parameter RR_EN, default 0: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports named as the codebase names them: wb_clk and wb_rst.
REQ-006 Ports, in this order (N = NUM_MASTERS, all master buses packed with master k at slice k):
- wb_clk  in  1  Wishbone clock.
- wb_rst  in  1  asynchronous active-high reset.
- m_cti_i  in  3*N  master cycle type.
- m_bte_i  in  2*N  master burst extension.
- m_adr_i  in  AW*N  master address.
- m_dat_i  in  DW*N  master write data.
- m_sel_i  in  (DW/8)*N  master byte select.
- m_cyc_i  in  N  master cycle request.
- m_stb_i  in  N  master strobe.
- m_we_i  in  N  master write enable.
- m_dat_o  out  DW*N  read data to masters.
- m_ack_o  out  N  ack to masters.
- s_cti_o  out  3  slave cycle type.
- s_bte_o  out  2  slave burst extension.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte select.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave ack.
- gnt_o  out  N  one-hot registered grant (all zero when idle).

Function
REQ-007 SHALL implement a two-state FSM, IDLE and GRANT, with a registered one-hot grant vector gnt and a registered last-granted index last.
REQ-008 In IDLE, if any m_cyc_i bit is set, SHALL load gnt with the arbitration winner and enter GRANT on the next wb_clk edge; otherwise it SHALL remain in IDLE.
REQ-009 When RR_EN=0, the winner SHALL be the highest-index master with m_cyc_i set.
REQ-010 When RR_EN=1, the winner SHALL be the first requester found searching upward from index (last+1) mod N, wrapping from N-1 to 0.
REQ-011 In GRANT, the slave outputs (s_cti_o, s_bte_o, s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o) SHALL combinationally follow the granted master's slice.
REQ-012 In IDLE, all slave outputs SHALL be zero.
REQ-013 m_ack_o[k] SHALL equal gnt[k] AND s_ack_i.
REQ-014 m_dat_o slice k SHALL equal s_dat_i when gnt[k] is set, and zero otherwise.
REQ-015 Grant is non-preemptive: requests from other masters while in GRANT SHALL be ignored, and their m_stb_i SHALL never produce an ack.
REQ-016 In GRANT, when the granted master's m_cyc_i is low at a clock edge, the block SHALL return to IDLE, clear gnt, and update last to the granted index.
REQ-017 Consequently, at least one IDLE cycle (s_cyc_o=0) SHALL separate consecutive grants, including re-grant of the same master.
REQ-018 Latency: for a request sampled at edge t, s_cyc_o SHALL rise in the cycle following edge t; the block SHALL add no latency to stb/ack once granted.
REQ-019 Simultaneous requests SHALL be resolved per REQ-009/REQ-010; exactly one gnt bit SHALL be set in GRANT.
REQ-020 When NUM_MASTERS=1, the block SHALL behave as a pass-through with one IDLE cycle before each cycle and one IDLE cycle after each cycle.
REQ-021 gnt_o SHALL equal gnt.

Reset
REQ-022 Asserting wb_rst SHALL immediately, without waiting for a clock, force state=IDLE, gnt=0, and last=N-1, so that under round-robin master 0 is first.
REQ-023 During reset, all outputs SHALL be zero: gnt_o, m_ack_o, m_dat_o, and all s_* outputs.
REQ-024 Reset asserted mid-cycle SHALL drop s_cyc_o asynchronously; after release, arbitration SHALL restart from IDLE.

Verification
REQ-025 Fixed priority, N=2, RR_EN=0: m_cyc_i=2'b11 from IDLE -> gnt_o=2'b10 next edge; master 0 receives no ack until master 1 drops cyc, then one IDLE cycle, then gnt_o=2'b01.
REQ-026 Round-robin, N=4, RR_EN=1: all four masters hold cyc continuously, each ending after 3 acks -> grant order 0,1,2,3,0, with s_cyc_o=0 for exactly one cycle between grants.
REQ-027 Burst pass-through: master 2 issues a 4-beat incrementing burst (cti 010,010,010,111) at adr 0x100..0x10C -> s_adr_o/s_cti_o match every beat; m_ack_o[2] mirrors s_ack_i; m_dat_o slice 2 = s_dat_i (e.g. 0xDEADBEEF); other slices 0.
REQ-028 Non-preemption: master 1 is granted under RR_EN=0 and master 3 raises cyc/stb mid-cycle -> gnt_o unchanged and m_ack_o[3]=0 until master 1 releases.
REQ-029 Reset mid-burst: wb_rst pulses between clock edges during GRANT -> s_cyc_o=0 and gnt_o=0 before the next edge; after release with m_cyc_i=4'b0001 and RR_EN=1 -> gnt_o=4'b0001.
REQ-030 N=1 pass-through: a single write (adr 0x40, dat 0x12345678, sel 4'hF) -> appears on s_* one cycle after cyc rises; m_ack_o[0]=s_ack_i.
